// File: rtl/uart_msg_pkg.sv
// Message format, header codes and shared types for the test-harness UART protocol.
// A message is {payload, header}, and the header sits in the LSBs.
package uart_msg_pkg;

  localparam int unsigned HDR_W = 8;
  localparam int unsigned PAY_W = 64;
  localparam int unsigned MSG_W = PAY_W + HDR_W;
  localparam int unsigned MOD_W = 64;
  localparam int unsigned MEM_W = 64;
  localparam int unsigned NUM_W = 64;

  localparam logic [MOD_W-1:0] MOD_RESET = '0;
  localparam logic [MEM_W-1:0] MEM_RESET = '0;

  localparam logic [HDR_W-1:0] ACK                   = 8'h01;
  localparam logic [HDR_W-1:0] RECEIVED_NUM          = 8'h02;
  localparam logic [HDR_W-1:0] REPLACE_NUM           = 8'h03;
  localparam logic [HDR_W-1:0] SYS_STATUS            = 8'h04;
  localparam logic [HDR_W-1:0] MOD_PARAMS            = 8'h05;
  localparam logic [HDR_W-1:0] MEM_PARAMS            = 8'h06;
  localparam logic [HDR_W-1:0] ERR_INVALID_MSG       = 8'h10;
  localparam logic [HDR_W-1:0] ERR_UPDATE_WHILST_RUN = 8'h11;
  localparam logic [HDR_W-1:0] ERR_FIFO_FULL         = 8'h12;
  localparam logic [HDR_W-1:0] ERR_MEM_OVERRUN       = 8'h13;

  typedef struct packed {
    logic [PAY_W-1:0] payload;
    logic [HDR_W-1:0] header;
  } uart_msg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SEND
  } ctrl_state_t;

  // Identifies which pending error flag (if any) the queued reply retires.
  typedef enum logic [1:0] {
    SRC_REPLY,
    SRC_FULL,
    SRC_OVERRUN
  } reply_src_t;

  function automatic logic [MSG_W-1:0] reply(input logic [PAY_W-1:0] d,
                                             input logic [HDR_W-1:0] h);
    return {d, h};
  endfunction

endpackage

// File: rtl/test_harness_controller.sv
// Host command/status controller: decodes RX messages, owns run/param registers,
// and returns one reply per command, memory number or error edge to the UART TX.
module test_harness_controller
  import uart_msg_pkg::*;
#(
  parameter logic [MOD_W-1:0] DEF_MOD = MOD_RESET,
  parameter logic [MEM_W-1:0] DEF_MEM = MEM_RESET
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             uart_in_avail,
  input  logic             uart_in_full,
  input  logic [MSG_W-1:0] uart_in_msg,
  output logic             uart_in_req,
  input  logic             uart_out_ready,
  output logic [MSG_W-1:0] uart_out_msg,
  output logic             uart_out_req,
  input  logic             mem_valid,
  input  logic [NUM_W-1:0] mem_received_num,
  output logic             mem_ack,
  input  logic             mem_overrun,
  output logic             mem_replace_valid,
  output logic [NUM_W-1:0] mem_replace_num,
  output logic [MEM_W-1:0] mem_params,
  output logic [MOD_W-1:0] mod_params,
  output logic             run
);

  ctrl_state_t      state, state_nx;
  reply_src_t       src, src_nx;
  logic [MSG_W-1:0] cmd, cmd_nx;
  uart_msg_t        cmd_f;

  logic             full_q, overrun_q;
  logic             rise_full, rise_overrun;
  logic             pend_full, pend_overrun;
  logic             clr_full, clr_overrun;

  logic             in_req_nx, out_req_nx, mem_ack_nx, rep_valid_nx, run_nx;
  logic [MSG_W-1:0] out_msg_nx;
  logic [NUM_W-1:0] rep_num_nx;
  logic [MOD_W-1:0] mod_nx;
  logic [MEM_W-1:0] mem_nx;

  assign cmd_f        = uart_msg_t'(cmd);
  assign rise_full    = uart_in_full & ~full_q;
  assign rise_overrun = mem_overrun & ~overrun_q;

  // Next-state, reply and register-update decode.
  always_comb begin
    state_nx     = state;
    src_nx       = src;
    cmd_nx       = cmd;
    out_msg_nx   = uart_out_msg;
    in_req_nx    = 1'b0;
    out_req_nx   = 1'b0;
    mem_ack_nx   = 1'b0;
    rep_valid_nx = 1'b0;
    rep_num_nx   = mem_replace_num;
    mod_nx       = mod_params;
    mem_nx       = mem_params;
    run_nx       = run;
    clr_full     = 1'b0;
    clr_overrun  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pend_overrun) begin
          out_msg_nx = reply('0, ERR_MEM_OVERRUN);
          src_nx     = SRC_OVERRUN;
          state_nx   = ST_SEND;
        end else if (pend_full) begin
          out_msg_nx = reply('0, ERR_FIFO_FULL);
          src_nx     = SRC_FULL;
          state_nx   = ST_SEND;
        end else if (mem_valid) begin
          mem_ack_nx = 1'b1;
          out_msg_nx = reply(PAY_W'(mem_received_num), RECEIVED_NUM);
          src_nx     = SRC_REPLY;
          state_nx   = ST_SEND;
        end else if (uart_in_avail) begin
          in_req_nx = 1'b1;
          cmd_nx    = uart_in_msg;
          state_nx  = ST_EXEC;
        end
      end

      ST_EXEC: begin
        src_nx   = SRC_REPLY;
        state_nx = ST_SEND;
        case (cmd_f.header)
          REPLACE_NUM: begin
            rep_valid_nx = 1'b1;
            rep_num_nx   = cmd_f.payload[NUM_W-1:0];
            out_msg_nx   = reply(cmd[PAY_W-1:0], ACK);
          end
          SYS_STATUS: begin
            run_nx     = cmd_f.payload[0];
            out_msg_nx = reply(cmd[PAY_W-1:0], ACK);
          end
          MOD_PARAMS: begin
            if (run) begin
              out_msg_nx = reply(cmd[PAY_W-1:0], ERR_UPDATE_WHILST_RUN);
            end else begin
              mod_nx     = cmd_f.payload[MOD_W-1:0];
              out_msg_nx = reply(cmd[PAY_W-1:0], ACK);
            end
          end
          MEM_PARAMS: begin
            if (run) begin
              out_msg_nx = reply(cmd[PAY_W-1:0], ERR_UPDATE_WHILST_RUN);
            end else begin
              mem_nx     = cmd_f.payload[MEM_W-1:0];
              out_msg_nx = reply(cmd[PAY_W-1:0], ACK);
            end
          end
          default: begin
            out_msg_nx = reply(cmd[PAY_W-1:0], ERR_INVALID_MSG);
          end
        endcase
      end

      ST_SEND: begin
        if (uart_out_ready) begin
          out_req_nx  = 1'b1;
          clr_full    = (src == SRC_FULL);
          clr_overrun = (src == SRC_OVERRUN);
          state_nx    = ST_IDLE;
        end
      end

      default: state_nx = ST_IDLE;
    endcase

    // An error edge stops the system even if EXEC is writing run this cycle.
    if (rise_full || rise_overrun) begin
      run_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Error edge detection and pending flags; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      full_q       <= 1'b0;
      overrun_q    <= 1'b0;
      pend_full    <= 1'b0;
      pend_overrun <= 1'b0;
    end else begin
      full_q       <= uart_in_full;
      overrun_q    <= mem_overrun;
      pend_full    <= rise_full | (pend_full & ~clr_full);
      pend_overrun <= rise_overrun | (pend_overrun & ~clr_overrun);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      src               <= SRC_REPLY;
      cmd               <= '0;
      uart_out_msg      <= '0;
      uart_in_req       <= 1'b0;
      uart_out_req      <= 1'b0;
      mem_ack           <= 1'b0;
      mem_replace_valid <= 1'b0;
      mem_replace_num   <= '0;
      mod_params        <= DEF_MOD;
      mem_params        <= DEF_MEM;
      run               <= 1'b0;
    end else begin
      src               <= src_nx;
      cmd               <= cmd_nx;
      uart_out_msg      <= out_msg_nx;
      uart_in_req       <= in_req_nx;
      uart_out_req      <= out_req_nx;
      mem_ack           <= mem_ack_nx;
      mem_replace_valid <= rep_valid_nx;
      mem_replace_num   <= rep_num_nx;
      mod_params        <= mod_nx;
      mem_params        <= mem_nx;
      run               <= run_nx;
    end
  end

endmodule

// File: tb/tb_test_harness_controller.sv
// Bench for test_harness_controller: RX FIFO model, TX/replace scoreboards,
// a command vector table and hand-written memory, error and reset sequences.
module tb_test_harness_controller;
  import uart_msg_pkg::*;

  logic             clk = 1'b0;
  logic             n_reset;
  logic             uart_in_avail = 1'b0;
  logic             uart_in_full;
  logic [MSG_W-1:0] uart_in_msg = '0;
  logic             uart_in_req;
  logic             uart_out_ready;
  logic [MSG_W-1:0] uart_out_msg;
  logic             uart_out_req;
  logic             mem_valid;
  logic [NUM_W-1:0] mem_received_num;
  logic             mem_ack;
  logic             mem_overrun;
  logic             mem_replace_valid;
  logic [NUM_W-1:0] mem_replace_num;
  logic [MEM_W-1:0] mem_params;
  logic [MOD_W-1:0] mod_params;
  logic             run;

  test_harness_controller dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .uart_in_avail    (uart_in_avail),
    .uart_in_full     (uart_in_full),
    .uart_in_msg      (uart_in_msg),
    .uart_in_req      (uart_in_req),
    .uart_out_ready   (uart_out_ready),
    .uart_out_msg     (uart_out_msg),
    .uart_out_req     (uart_out_req),
    .mem_valid        (mem_valid),
    .mem_received_num (mem_received_num),
    .mem_ack          (mem_ack),
    .mem_overrun      (mem_overrun),
    .mem_replace_valid(mem_replace_valid),
    .mem_replace_num  (mem_replace_num),
    .mem_params       (mem_params),
    .mod_params       (mod_params),
    .run              (run)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [HDR_W-1:0] hdr;
    logic [PAY_W-1:0] pay;
    logic [HDR_W-1:0] exp_hdr;
    logic             exp_run;
    logic [MOD_W-1:0] exp_mod;
    logic [MEM_W-1:0] exp_mem;
    logic             rep;
  } vec_t;

  localparam int unsigned NVEC = 12;
  vec_t vecs[NVEC];

  logic [MSG_W-1:0] rx_q[$];
  logic [MSG_W-1:0] exp_q[$];
  logic [NUM_W-1:0] rep_q[$];

  int   errors   = 0;
  int   checks   = 0;
  int   tx_count = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [MSG_W-1:0] act,
                       input logic [MSG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RX FIFO pops on the edge that sees the request strobe.
  always @(posedge clk) begin
    if (uart_in_req && rx_q.size() != 0) void'(rx_q.pop_front());
  end

  // Output monitor / scoreboard and show-ahead FIFO head update.
  always @(negedge clk) begin
    if (n_reset) begin
      if (uart_out_req) begin
        tx_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %h expected no message", uart_out_msg);
        end else begin
          check("tx_msg", uart_out_msg, exp_q.pop_front());
        end
      end
      if (mem_replace_valid) begin
        if (rep_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL replace_unexpected: got %h expected no strobe", mem_replace_num);
        end else begin
          check("replace_num", MSG_W'(mem_replace_num), MSG_W'(rep_q.pop_front()));
        end
      end
      if (uart_in_req) check("in_req_single_pulse", MSG_W'(prev_req), '0);
    end
    prev_req      = uart_in_req;
    uart_in_avail = (rx_q.size() != 0);
    uart_in_msg   = (rx_q.size() != 0) ? rx_q[0] : '0;
  end

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0 || rep_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d replies outstanding expected 0", exp_q.size());
      exp_q.delete();
      rep_q.delete();
      rx_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [HDR_W-1:0] hdr, input logic [PAY_W-1:0] pay,
                          input logic [HDR_W-1:0] exp_hdr);
    logic [MSG_W-1:0] m;
    m = {pay, hdr};
    rx_q.push_back(m);
    exp_q.push_back({m[PAY_W-1:0], exp_hdr});
  endtask

  task automatic mem_txn(input logic [NUM_W-1:0] num);
    int n = 0;
    @(negedge clk);
    mem_received_num = num;
    mem_valid        = 1'b1;
    exp_q.push_back({PAY_W'(num), RECEIVED_NUM});
    while (!mem_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mem_ack_seen", MSG_W'(mem_ack), MSG_W'(1));
    mem_valid = 1'b0;
    @(negedge clk);
    check("mem_ack_one_cycle", MSG_W'(mem_ack), '0);
    drain();
  endtask

  task automatic error_hold(input bit use_full, input logic [HDR_W-1:0] exp_hdr);
    @(negedge clk);
    if (use_full) uart_in_full = 1'b1;
    else mem_overrun = 1'b1;
    exp_q.push_back({64'h0, exp_hdr});
    repeat (2) @(negedge clk);
    check(use_full ? "run_after_full" : "run_after_overrun", MSG_W'(run), '0);
    repeat (100) @(negedge clk);
    uart_in_full = 1'b0;
    mem_overrun  = 1'b0;
    drain();
  endtask

  localparam logic [63:0] P1 = 64'hA1B2_C3D4_1111_0001;
  localparam logic [63:0] P2 = 64'hF0E1_2222_3333_0002;
  localparam logic [63:0] P3 = 64'h3333_4444_5555_6666;
  localparam logic [63:0] P4 = 64'h7777_8888_9999_AAAA;
  localparam logic [63:0] R1 = 64'hDEAD_BEEF_0000_0003;
  localparam logic [63:0] R2 = 64'hCAFE_F00D_1234_5678;

  initial begin
    int n;
    int tx_before;

    vecs[0]  = '{MOD_PARAMS,  P1,                    ACK,                   1'b0, P1, '0, 1'b0};
    vecs[1]  = '{MEM_PARAMS,  P2,                    ACK,                   1'b0, P1, P2, 1'b0};
    vecs[2]  = '{REPLACE_NUM, R1,                    ACK,                   1'b0, P1, P2, 1'b1};
    vecs[3]  = '{8'hFF,       64'h1234,              ERR_INVALID_MSG,       1'b0, P1, P2, 1'b0};
    vecs[4]  = '{SYS_STATUS,  64'h1,                 ACK,                   1'b1, P1, P2, 1'b0};
    vecs[5]  = '{MOD_PARAMS,  P3,                    ERR_UPDATE_WHILST_RUN, 1'b1, P1, P2, 1'b0};
    vecs[6]  = '{MEM_PARAMS,  P4,                    ERR_UPDATE_WHILST_RUN, 1'b1, P1, P2, 1'b0};
    vecs[7]  = '{REPLACE_NUM, R2,                    ACK,                   1'b1, P1, P2, 1'b1};
    vecs[8]  = '{SYS_STATUS,  64'hFFFF_FFFF_FFFF_FFFE, ACK,                 1'b0, P1, P2, 1'b0};
    vecs[9]  = '{MOD_PARAMS,  P1,                    ACK,                   1'b0, P1, P2, 1'b0};
    vecs[10] = '{8'h00,       64'h5,                 ERR_INVALID_MSG,       1'b0, P1, P2, 1'b0};
    vecs[11] = '{SYS_STATUS,  64'h8000_0000_0000_0001, ACK,                 1'b1, P1, P2, 1'b0};

    n_reset          = 1'b0;
    uart_in_full     = 1'b0;
    uart_out_ready   = 1'b1;
    mem_valid        = 1'b0;
    mem_received_num = '0;
    mem_overrun      = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_run", MSG_W'(run), '0);
    check("reset_mod", MSG_W'(mod_params), '0);
    check("reset_mem", MSG_W'(mem_params), '0);
    check("reset_strobes",
          MSG_W'({uart_in_req, uart_out_req, mem_ack, mem_replace_valid}), '0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < int'(NVEC); i++) begin
      send_cmd(vecs[i].hdr, vecs[i].pay, vecs[i].exp_hdr);
      if (vecs[i].rep) rep_q.push_back(vecs[i].pay);
      drain();
      check($sformatf("vec%0d_run", i), MSG_W'(run), MSG_W'(vecs[i].exp_run));
      check($sformatf("vec%0d_mod", i), MSG_W'(mod_params), MSG_W'(vecs[i].exp_mod));
      check($sformatf("vec%0d_mem", i), MSG_W'(mem_params), MSG_W'(vecs[i].exp_mem));
    end

    mem_txn(64'h0123_4567_89AB_CDEF);
    mem_txn(64'hFFFF_FFFF_FFFF_FFFF);

    // run=1 from the last vector; a held overrun gives one message and stops the system.
    error_hold(1'b0, ERR_MEM_OVERRUN);
    send_cmd(SYS_STATUS, 64'h1, ACK);
    drain();
    check("run_restart", MSG_W'(run), MSG_W'(1));
    error_hold(1'b1, ERR_FIFO_FULL);

    // Backpressure, and an error edge that lands while a reply is waiting in SEND.
    uart_out_ready = 1'b0;
    tx_before      = tx_count;
    send_cmd(8'hFF, 64'hABCD, ERR_INVALID_MSG);
    repeat (10) @(negedge clk);
    mem_overrun = 1'b1;
    exp_q.push_back({64'h0, ERR_MEM_OVERRUN});
    repeat (3) @(negedge clk);
    mem_overrun = 1'b0;
    repeat (5) @(negedge clk);
    check("no_tx_while_not_ready", MSG_W'(tx_count), MSG_W'(tx_before));
    uart_out_ready = 1'b1;
    drain();
    check("tx_after_ready", MSG_W'(tx_count), MSG_W'(tx_before + 2));

    // Reset with a reply in flight discards it and restores defaults.
    send_cmd(SYS_STATUS, 64'h1, ACK);
    drain();
    uart_out_ready = 1'b0;
    send_cmd(8'hFF, 64'h77, ERR_INVALID_MSG);
    n = 0;
    while (rx_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    tx_before = tx_count;
    n_reset   = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("reset2_run", MSG_W'(run), '0);
    check("reset2_mod", MSG_W'(mod_params), '0);
    check("reset2_mem", MSG_W'(mem_params), '0);
    check("reset2_strobes",
          MSG_W'({uart_in_req, uart_out_req, mem_ack, mem_replace_valid}), '0);
    uart_out_ready = 1'b1;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (30) @(negedge clk);
    check("reset2_no_tx", MSG_W'(tx_count), MSG_W'(tx_before));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
